// File: rtl/iccm_loader.sv
// iccm_loader: packs a little-endian byte stream into 32-bit words and writes
// them sequentially into the ICCM starting at word address 0, holding the core
// while a load is in progress.
module iccm_loader #(
  parameter int unsigned DataWidth = 32,  // only 32 is supported
  parameter int unsigned AddrWidth = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 i_start,
  input  logic [AddrWidth:0]   i_word_count,
  input  logic [7:0]           i_byte,
  input  logic                 i_byte_valid,
  output logic                 o_byte_ready,
  output logic [AddrWidth-1:0] o_iccm_addr,
  output logic [DataWidth-1:0] o_iccm_data,
  output logic                 o_iccm_write,
  output logic                 o_iccm_read,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_core_hold
);

  localparam int unsigned CntW = AddrWidth + 1;
  // DEPTH = 2**AddrWidth, the largest count that never wraps the address
  localparam logic [CntW-1:0] Depth = CntW'(1) << AddrWidth;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [CntW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [1:0]             idx_q, idx_d;
  logic [DataWidth-1:0]   word_q, word_d;

  logic                   ready_q, ready_d;
  logic [AddrWidth-1:0]   iaddr_q, iaddr_d;
  logic [DataWidth-1:0]   idata_q, idata_d;
  logic                   write_q, write_d;
  logic                   read_q, read_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [CntW-1:0]        count_clamp;
  logic [CntW-1:0]        wr_cnt_inc;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_cnt_d    = wr_cnt_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    word_d      = word_q;
    iaddr_d     = iaddr_q;
    idata_d     = idata_q;
    count_clamp = (i_word_count > Depth) ? Depth : i_word_count;
    wr_cnt_inc  = CntW'(wr_cnt_q + CntW'(1));

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          count_d  = count_clamp;
          wr_cnt_d = '0;
          addr_d   = '0;
          idx_d    = '0;
          state_d  = (count_clamp == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        // ready is high for the whole of COLLECT, so valid alone is a transfer
        if (i_byte_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = i_byte;
          idx_d = 2'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d   = AddrWidth'(addr_q + AddrWidth'(1));
        wr_cnt_d = wr_cnt_inc;
        state_d  = (wr_cnt_inc == count_q) ? DONE : COLLECT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Address/data outputs only change on entry to WRITE and hold otherwise
    if ((state_d == WRITE) && (state_q != WRITE)) begin
      iaddr_d = addr_q;
      idata_d = word_d;
    end

    ready_d = (state_d == COLLECT);
    write_d = (state_d == WRITE);
    read_d  = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and output registers with asynchronous active-high reset
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      ready_q  <= 1'b0;
      iaddr_q  <= '0;
      idata_q  <= '0;
      write_q  <= 1'b0;
      read_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      ready_q  <= ready_d;
      iaddr_q  <= iaddr_d;
      idata_q  <= idata_d;
      write_q  <= write_d;
      read_q   <= read_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_iccm_addr  = iaddr_q;
  assign o_iccm_data  = idata_q;
  assign o_iccm_write = write_q;
  assign o_iccm_read  = read_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_core_hold  = busy_q;

endmodule
